pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Generates the stage-register enables, flushes and the MEM/WB bubble from
// load-use hazards, data-memory wait states, taken branches and a halt
// request. A drain sequence lets the back end retire before stopping.
// A saturating counter tracks the number of frontend-stall cycles.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] stall_count
);

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_LDUSE = 3'd1;
    localparam logic [2:0] ST_MWAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    // Number of DRAIN cycles minus one: three non-stalled cycles empty the
    // stages behind IF before the pipeline stops.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    logic [2:0]  state_reg, state_next;
    logic [1:0]  drain_cnt_reg, drain_cnt_next;
    logic [15:0] stall_count_reg, stall_count_next;

    logic load_use;
    logic mem_stall;

    // Hazard detection; X31 reads as zero so it never creates a dependency.
    always_comb begin
        load_use  = ex_mem_read && (ex_rd != 5'd31) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        mem_stall = mem_req && !mem_ready;
    end

    // Output and next-state decode. States that defer to the RUN rules set
    // apply_run with possibly masked hazard inputs; the RUN rules are then
    // evaluated once after the per-state case.
    always_comb begin
        logic apply_run;
        logic eff_ms;
        logic eff_lu;

        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        memwb_bubble   = 1'b0;
        halted         = 1'b0;
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        apply_run      = 1'b0;
        eff_ms         = mem_stall;
        eff_lu         = load_use;

        case (state_reg)
            ST_RUN: begin
                apply_run = 1'b1;
            end
            ST_LDUSE: begin
                // The stall cycle has already been spent on this hazard.
                apply_run = 1'b1;
                eff_lu    = 1'b0;
            end
            ST_MWAIT: begin
                if (!mem_ready) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    state_next   = ST_MWAIT;
                end else begin
                    apply_run = 1'b1;
                    eff_ms    = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (mem_stall) begin
                    // Freeze everything; the drain counter holds.
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end else begin
                    pc_en          = 1'b0;
                    ifid_flush     = 1'b1;
                    drain_cnt_next = drain_cnt_reg + 2'd1;
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halted   = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (apply_run) begin
            state_next = ST_RUN;
            if (eff_ms) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_en     = 1'b0;
                memwb_bubble = 1'b1;
                state_next   = ST_MWAIT;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (eff_lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                state_next = ST_LDUSE;
            end else if (halt_req) begin
                pc_en          = 1'b0;
                ifid_flush     = 1'b1;
                drain_cnt_next = 2'd0;
                state_next     = ST_DRAIN;
            end
        end

        if (rst) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            idex_en        = 1'b0;
            exmem_en       = 1'b0;
            memwb_en       = 1'b0;
            ifid_flush     = 1'b0;
            idex_flush     = 1'b0;
            memwb_bubble   = 1'b0;
            halted         = 1'b0;
            state_next     = ST_RUN;
            drain_cnt_next = 2'd0;
        end
    end

    // Frontend-stall counter: only RUN, LDUSE and MWAIT cycles with the PC
    // held are counted; the count sticks at all-ones.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (rst) begin
            stall_count_next = 16'd0;
        end else if (!pc_en &&
                     ((state_reg == ST_RUN) || (state_reg == ST_LDUSE) ||
                      (state_reg == ST_MWAIT)) &&
                     (stall_count_reg != 16'hFFFF)) begin
            stall_count_next = stall_count_reg + 16'd1;
        end
    end

    // State, drain counter and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            drain_cnt_reg   <= 2'd0;
            stall_count_reg <= 16'd0;
        end else begin
            state_reg       <= state_next;
            drain_cnt_reg   <= drain_cnt_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign state       = state_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, memory waits, branch
// priority, halt drain, reset and stall-counter saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        halt_req;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        memwb_bubble;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    // {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush, bubble, halted}
    localparam logic [8:0] C_RUN    = 9'b11111_00_0_0;
    localparam logic [8:0] C_FREEZE = 9'b00000_00_1_0;
    localparam logic [8:0] C_BR     = 9'b11111_11_0_0;
    localparam logic [8:0] C_LU     = 9'b00111_01_0_0;
    localparam logic [8:0] C_DRAIN  = 9'b01111_10_0_0;
    localparam logic [8:0] C_HALT   = 9'b00000_00_0_1;
    localparam logic [8:0] C_RST    = 9'b00000_00_0_0;

    logic [8:0] ctl;
    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_bubble, halted};

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .halt_req        (halt_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
        .halted          (halted),
        .state           (state),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [8:0] exp_ctl,
                        input logic [2:0] exp_st, input logic [15:0] exp_cnt);
        @(negedge clk);
        $display("step %-14s ctl=%b state=%0d stall_count=%0d", tag, ctl, state, stall_count);
        check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        check({tag, ".state"}, 32'(state), 32'(exp_st));
        check({tag, ".cnt"}, 32'(stall_count), 32'(exp_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("reset", C_RST, 3'd0, 16'd0);
        rst = 1'b0;
        step("idle", C_RUN, 3'd0, 16'd0);

        // Load-use: one stall cycle, LDUSE ignores the still-present hazard.
        set_lu();
        step("lu_stall", C_LU, 3'd0, 16'd0);
        step("lu_ldstate", C_RUN, 3'd1, 16'd1);
        idle();
        step("lu_back", C_RUN, 3'd0, 16'd1);

        // XZR and rs2 qualification.
        ex_mem_read = 1'b1; ex_rd = 5'd31; id_rs1 = 5'd31;
        step("xzr", C_RUN, 3'd0, 16'd1);
        id_rs1 = 5'd0; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        step("rs2_unused", C_RUN, 3'd0, 16'd1);
        id_uses_rs2 = 1'b1;
        step("rs2_used", C_LU, 3'd0, 16'd1);
        idle();
        step("rs2_ldstate", C_RUN, 3'd1, 16'd2);
        step("rs2_back", C_RUN, 3'd0, 16'd2);

        // Memory wait of three cycles.
        mem_req = 1'b1; mem_ready = 1'b0;
        step("mw1", C_FREEZE, 3'd0, 16'd2);
        step("mw2", C_FREEZE, 3'd2, 16'd3);
        step("mw3", C_FREEZE, 3'd2, 16'd4);
        mem_ready = 1'b1;
        step("mw_release", C_RUN, 3'd2, 16'd5);
        idle();
        step("mw_back", C_RUN, 3'd0, 16'd5);

        // Branch beats load-use.
        set_lu(); ex_branch_taken = 1'b1;
        step("br_lu", C_BR, 3'd0, 16'd5);
        idle();
        step("br_lu_after", C_RUN, 3'd0, 16'd5);

        // mem_stall beats branch; flush happens on the ready cycle.
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        step("ms_br_frz", C_FREEZE, 3'd0, 16'd5);
        mem_ready = 1'b1;
        step("ms_br_flush", C_BR, 3'd2, 16'd6);
        idle();
        step("ms_br_after", C_RUN, 3'd0, 16'd6);

        // Load-use present on the MWAIT release cycle.
        mem_req = 1'b1; mem_ready = 1'b0;
        step("ms_lu_frz", C_FREEZE, 3'd0, 16'd6);
        mem_ready = 1'b1; set_lu();
        step("ms_lu_rel", C_LU, 3'd2, 16'd7);
        idle();
        step("ms_lu_ld", C_RUN, 3'd1, 16'd8);
        step("ms_lu_back", C_RUN, 3'd0, 16'd8);

        // Halt with one memory stall inserted into the drain.
        halt_req = 1'b1;
        step("halt_req", C_DRAIN, 3'd0, 16'd8);
        idle(); set_lu(); ex_branch_taken = 1'b1; halt_req = 1'b1;
        step("drain0", C_DRAIN, 3'd3, 16'd9);
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        step("drain_ms", C_FREEZE, 3'd3, 16'd9);
        idle();
        step("drain1", C_DRAIN, 3'd3, 16'd9);
        step("drain2", C_DRAIN, 3'd3, 16'd9);
        step("halt1", C_HALT, 3'd4, 16'd9);
        ex_branch_taken = 1'b1; halt_req = 1'b1; mem_req = 1'b1;
        step("halt2", C_HALT, 3'd4, 16'd9);
        idle();

        // Reset out of HALT.
        rst = 1'b1;
        step("rst_halt", C_RST, 3'd4, 16'd9);
        rst = 1'b0;
        step("rst_post", C_RUN, 3'd0, 16'd0);

        // Reset mid-MWAIT.
        mem_req = 1'b1; mem_ready = 1'b0;
        step("rmw1", C_FREEZE, 3'd0, 16'd0);
        step("rmw2", C_FREEZE, 3'd2, 16'd1);
        rst = 1'b1;
        step("rmw_rst", C_RST, 3'd2, 16'd2);
        rst = 1'b0; idle();
        step("rmw_post", C_RUN, 3'd0, 16'd0);

        // Reset mid-DRAIN.
        halt_req = 1'b1;
        step("rdr_halt", C_DRAIN, 3'd0, 16'd0);
        idle();
        step("rdr_drain", C_DRAIN, 3'd3, 16'd1);
        rst = 1'b1;
        step("rdr_rst", C_RST, 3'd3, 16'd1);
        rst = 1'b0;
        step("rdr_post", C_RUN, 3'd0, 16'd0);

        // Saturation under a long memory wait.
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        step("sat1", C_FREEZE, 3'd2, 16'hFFFF);
        step("sat2", C_FREEZE, 3'd2, 16'hFFFF);
        mem_ready = 1'b1;
        step("sat_rel", C_RUN, 3'd2, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
